// File: rtl/ds_seq.sv
// ds_seq: sequenced divide-then-subtract unit.
// Computes quotient = x / y (unsigned) and difference = quotient - z.
// A restoring divider produces one quotient bit per cycle. A registered
// subtract stage follows it. Valid/ready handshakes are used on both
// sides, and only one operation is in flight at a time.
module ds_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] difference,
  output logic             div_by_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  // The dividend shifts out at the top while quotient bits shift in at
  // the bottom. After WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] zr;
  logic             dbz;

  logic [WIDTH:0]   trial;
  logic             take;
  logic [WIDTH-1:0] rem_next;

  // One restoring step: shift in the next dividend bit, then subtract
  // the divisor if it fits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    trial    = {rem, dvd[WIDTH-1]};
    take     = (trial >= {1'b0, dvs});
    rem_next = trial[WIDTH-1:0];
    if (take) begin
      // The true result is below dvs, so the low WIDTH bits are exact.
      rem_next = trial[WIDTH-1:0] - dvs;
    end
  end

  // Status flags are decoded directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Control FSM, working registers and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      zr          <= '0;
      dbz         <= 1'b0;
      quotient    <= '0;
      difference  <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvs <= y;
            zr  <= z;
            rem <= '0;
            cnt <= '0;
            if (y == '0) begin
              dvd   <= '1;
              dbz   <= 1'b1;
              state <= SUB;
            end else begin
              dvd   <= x;
              dbz   <= 1'b0;
              state <= DIV;
            end
          end
        end
        DIV: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            rem <= rem_next;
            dvd <= {dvd[WIDTH-2:0], take};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state <= SUB;
            end
          end
        end
        SUB: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            quotient    <= dvd;
            difference  <= dvd - zr;
            div_by_zero <= dbz;
            state       <= DONE;
          end
        end
        DONE: begin
          // The result stays presented until it is consumed. Abort has no effect here.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_seq.sv
// Self-checking bench for ds_seq. Expected results are queued when an
// operation is issued and popped when the unit presents its result.
module tb_ds_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] z;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] difference;
  logic         div_by_zero;
  logic         busy;

  ds_seq #(.WIDTH(W), .CW(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z           (z),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .difference  (difference),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic         dbz;
    int           lat;
  } vec_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Advance one clock edge. Signals are sampled and driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and return 1 ns after the handshake edge.
  task automatic send(input logic [W-1:0] xi, input logic [W-1:0] yi, input logic [W-1:0] zi);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("issue_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    x = xi;
    y = yi;
    z = zi;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges from the handshake until out_valid rises (bounded).
  task automatic await_out(input string name, input int lat);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, lat);
  endtask

  // Compare the presented result with the scoreboard head, then consume it.
  task automatic consume(input string name);
    exp_t e;
    check({name, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, "_valid"}, out_valid, 1'b1);
      check({name, "_quotient"}, quotient, e.q);
      check({name, "_difference"}, difference, e.d);
      check({name, "_dbz"}, div_by_zero, e.dbz);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 1'b0);
  endtask

  vec_t vt[8];

  initial begin
    exp_t e;
    int   hits;
    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    x           = '0;
    y           = '0;
    z           = '0;
    abort       = 1'b0;
    out_ready   = 1'b0;

    vt[0] = '{x: 100,          y: 7,            z: 4, q: 14,           d: 10,           dbz: 1'b0, lat: 33};
    vt[1] = '{x: 5,            y: 10,           z: 1, q: 0,            d: 32'hFFFFFFFF, dbz: 1'b0, lat: 33};
    vt[2] = '{x: 32'hFFFFFFFF, y: 1,            z: 0, q: 32'hFFFFFFFF, d: 32'hFFFFFFFF, dbz: 1'b0, lat: 33};
    vt[3] = '{x: 123,          y: 0,            z: 5, q: 32'hFFFFFFFF, d: 32'hFFFFFFFA, dbz: 1'b1, lat: 1};
    vt[4] = '{x: 0,            y: 9,            z: 0, q: 0,            d: 0,            dbz: 1'b0, lat: 33};
    vt[5] = '{x: 32'hFFFFFFFF, y: 32'hFFFFFFFF, z: 1, q: 1,            d: 0,            dbz: 1'b0, lat: 33};
    vt[6] = '{x: 32'h80000000, y: 3,            z: 2, q: 32'h2AAAAAAA, d: 32'h2AAAAAA8, dbz: 1'b0, lat: 33};
    vt[7] = '{x: 7,            y: 7,            z: 8, q: 1,            d: 32'hFFFFFFF9, dbz: 1'b0, lat: 33};

    // Reset values.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_difference", difference, '0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Table-driven operations.
    foreach (vt[i]) begin
      send(vt[i].x, vt[i].y, vt[i].z);
      sb.push_back('{q: vt[i].q, d: vt[i].d, dbz: vt[i].dbz});
      check($sformatf("v%0d_in_ready_low", i), in_ready, 1'b0);
      await_out($sformatf("v%0d", i), vt[i].lat);
      consume($sformatf("v%0d", i));
    end

    // Back-pressure: the result holds for 10 cycles. An abort in DONE is ignored.
    send(100, 7, 4);
    sb.push_back('{q: 14, d: 10, dbz: 1'b0});
    await_out("bp", 33);
    e = sb[0];
    for (int c = 0; c < 10; c++) begin
      abort = (c == 5);
      tick();
      check($sformatf("bp%0d_valid", c), out_valid, 1'b1);
      check($sformatf("bp%0d_quotient", c), quotient, e.q);
      check($sformatf("bp%0d_difference", c), difference, e.d);
    end
    abort = 1'b0;
    // Consume while a new operand waits. It is not taken in DONE.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x = 50;
    y = 5;
    z = 3;
    check("bp_ready_in_done", in_ready, 1'b0);
    tick();
    void'(sb.pop_front());
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1'b1);
    check("bp_idle_valid", out_valid, 1'b0);
    sb.push_back('{q: 10, d: 7, dbz: 1'b0});
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", busy, 1'b1);
    await_out("bp2", 33);
    consume("bp2");

    // Abort in DIV: return to IDLE, no result, outputs keep 50/5 - 3.
    send(200, 3, 1);
    repeat (10) tick();
    check("ab_in_div", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_in_ready", in_ready, 1'b1);
    check("ab_quotient", quotient, 10);
    check("ab_difference", difference, 7);
    hits = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) hits++;
    end
    check("ab_no_valid", hits, 0);

    // Asynchronous reset mid-division takes effect without an edge.
    send(1000, 3, 0);
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("ar_in_ready", in_ready, 1'b1);
    check("ar_busy", busy, 1'b0);
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_quotient", quotient, '0);
    check("ar_difference", difference, '0);
    check("ar_dbz", div_by_zero, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // A fresh operation after reset.
    send(50, 5, 3);
    sb.push_back('{q: 10, d: 7, dbz: 1'b0});
    await_out("post", 33);
    consume("post");
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ds_seq.md
Name: ds_seq

Overview:
- Multi-cycle sequenced version of the divide-then-subtract datapath. It computes quotient = x / y (unsigned) and difference = quotient - z.
- Iterative restoring divider: one quotient bit per cycle, followed by a registered subtract stage.
- Valid/ready handshakes on input and output; one operation in flight at a time.
- Replaces the single-cycle combinational divider on timing-critical paths. It sits between the issue logic and the writeback of the execute stage.

Parameters:
- WIDTH, 32, operand and result width in bits. Legal values are 2 or greater.
- CW, 6, iteration counter width. Must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (low) resets all state immediately; deassertion is synchronous to clk.
- in_valid  input  1  operands x, y, z are valid.
- in_ready  output  1  block can accept operands.
- x  input  WIDTH  dividend.
- y  input  WIDTH  divisor.
- z  input  WIDTH  subtrahend.
- abort  input  1  synchronous cancel of the in-flight operation.
- out_valid  output  1  results are valid.
- out_ready  input  1  consumer accepts the results.
- quotient  output  WIDTH  registered x / y.
- difference  output  WIDTH  registered quotient - z.
- div_by_zero  output  1  the result came from y == 0.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst low): state=IDLE, quotient=0, difference=0, div_by_zero=0, out_valid=0, in_ready=1, busy=0, counter=0. Internal remainder/divisor/z registers are cleared.
- States: IDLE, DIV, SUB, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE, input handshake (in_valid & in_ready):
  - latch x, y, z; clear remainder; counter=0.
  - if y != 0, go to DIV.
  - if y == 0, preset quotient to all ones, set the div_by_zero flag internally, and go directly to SUB.
- DIV:
  - each cycle: shift remainder left, bringing in the MSB of the working dividend. If remainder >= divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - counter increments each cycle. When counter == WIDTH-1, go to SUB after this cycle's update.
  - exactly WIDTH cycles are spent in DIV.
- SUB:
  - difference = quotient - z, modulo 2^WIDTH (wrap, no borrow output).
  - outputs are registered and state goes to DONE.
- DONE:
  - quotient, difference and div_by_zero are stable while out_valid=1.
  - on out_ready, go to IDLE.
  - no new input is accepted in DONE, even if out_ready and in_valid are high in the same cycle. The new operand is accepted on the next cycle in IDLE.
- Latency from the input handshake edge:
  - y != 0: out_valid rises WIDTH+1 edges later (WIDTH in DIV, 1 in SUB).
  - y == 0: out_valid rises 1 edge later.
- Output registers (quotient, difference, div_by_zero):
  - updated only at the SUB->DONE transition.
  - they keep their last values in IDLE and during DIV.
  - the datapath uses internal working registers, so these outputs do not change mid-operation.
- abort:
  - in DIV or SUB: go to IDLE on that edge; output registers unchanged; out_valid is never asserted for the aborted operation.
  - in IDLE or DONE: ignored. In DONE the result is still presented.
  - abort has priority over the counter-terminal transition.
- Asynchronous reset mid-operation discards the operation and forces the reset values immediately, without waiting for a clock edge.
- Division is unsigned only.
  - x < y gives quotient 0.
  - x == 0 with y != 0 gives quotient 0, and still takes the full WIDTH cycles.

Test Plan:
- Reset values: hold rst low for 3 cycles, release. Required: in_ready=1, out_valid=0, quotient=0, difference=0, div_by_zero=0, busy=0.
- Basic op: x=100, y=7, z=4, handshake at edge 0. Required: out_valid high after edge 33; quotient=14, difference=10, div_by_zero=0. in_ready stays 0 from edge 1 until return to IDLE.
- Wrap and small quotient: x=5, y=10, z=1. Required: quotient=0, difference=0xFFFFFFFF. Separately, x=0xFFFFFFFF, y=1, z=0. Required: quotient=0xFFFFFFFF, difference=0xFFFFFFFF.
- Divide by zero: x=123, y=0, z=5. Required: out_valid high after 1 edge; quotient=0xFFFFFFFF, difference=0xFFFFFFFA, div_by_zero=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid rises. Required: outputs stable throughout. Then pulse out_ready with in_valid=1: in_ready=0 that cycle, and the operand is accepted on the following cycle.
- Abort and reset mid-op:
  - abort at DIV cycle 10. Required: return to IDLE next edge, no out_valid, outputs keep their previous result.
  - rst low during DIV. Required: reset values asserted immediately, without a clock edge.
  - new op 50/5, z=3. Required: quotient=10, difference=7.
